bios_boot_loader: RTL and testbench

BIOS_BOOT_LOADER -- requirements
Module: bios_boot_loader

---
 rtl/bios_boot_loader.sv | 141 ++++++++++++++
 tb/tb_bios_boot_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bios_boot_loader.sv
// Boot loader: copies DEPTH BIOS words into instruction memory, then pulses PC clear and releases the CPU.
// Latency: one START cycle, one cycle per acknowledged word, one RELEASE cycle, then DONE.
// Backpressure: waits on imem_wr_ack holding addr/data; TIMEOUT consecutive unacked cycles on one word -> FAULT.
//
// Ports:
//   clock, reset_n            sole clock, async active-low reset
//   bios_flat                 BIOS image, word k at [WORD_W*k +: WORD_W]
//   reload                    re-run the copy (honoured only in DONE / FAULT)
//   imem_wr_ack               instruction memory accepted the current write
//   imem_wr_en/addr/data      instruction memory write request
//   cpu_hold, cpu_pc_clear    CPU freeze and one-cycle PC reset pulse
//   boot_done, boot_error     copy finished / write timeout
//   words_loaded              acknowledged writes in the current pass
module bios_boot_loader #(
  parameter int WORD_W  = 16,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [DEPTH*WORD_W-1:0] bios_flat,
  input  logic                    reload,
  input  logic                    imem_wr_ack,
  output logic                    imem_wr_en,
  output logic [ADDR_W-1:0]       imem_wr_addr,
  output logic [WORD_W-1:0]       imem_wr_data,
  output logic                    cpu_hold,
  output logic                    cpu_pc_clear,
  output logic                    boot_done,
  output logic                    boot_error,
  output logic [ADDR_W:0]         words_loaded
);

  typedef enum logic [2:0] {
    ST_START   = 3'd0,
    ST_WRITE   = 3'd1,
    ST_RELEASE = 3'd2,
    ST_DONE    = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  // Wait count seen during the TIMEOUT-th consecutive unacked cycle.
  localparam logic [7:0]        WAIT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        wait_q, wait_d;
  logic [ADDR_W:0]   loaded_q, loaded_d;
  logic              wr_en_q, wr_en_d;
  logic              hold_q, hold_d;
  logic              pc_clear_q, pc_clear_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  // Unpack the flat image so the current word is a simple array lookup.
  logic [WORD_W-1:0] bios_word [DEPTH];
  for (genvar k = 0; k < DEPTH; k++) begin : g_unpack
    assign bios_word[k] = bios_flat[WORD_W*k +: WORD_W];
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wait_d   = wait_q;
    loaded_d = loaded_q;
    unique case (state_q)
      ST_START: begin
        idx_d    = '0;
        wait_d   = '0;
        loaded_d = '0;
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        // An ack in the last allowed cycle wins over the timeout.
        if (imem_wr_ack) begin
          loaded_d = loaded_q + (ADDR_W+1)'(1);
          wait_d   = '0;
          if (idx_q == LAST_IDX) begin
            state_d = ST_RELEASE;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_q == WAIT_LAST) begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_RELEASE: state_d = ST_DONE;
      ST_DONE:    if (reload) state_d = ST_START;
      ST_FAULT:   if (reload) state_d = ST_START;
      default:    state_d = ST_START;
    endcase
  end

  // Outputs are registered from the next state so they change in step with it.
  always_comb begin
    wr_en_d    = (state_d == ST_WRITE);
    hold_d     = (state_d != ST_DONE);
    pc_clear_d = (state_d == ST_RELEASE);
    done_d     = (state_d == ST_DONE);
    error_d    = (state_d == ST_FAULT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_START;
      idx_q      <= '0;
      wait_q     <= '0;
      loaded_q   <= '0;
      wr_en_q    <= 1'b0;
      hold_q     <= 1'b1;
      pc_clear_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wait_q     <= wait_d;
      loaded_q   <= loaded_d;
      wr_en_q    <= wr_en_d;
      hold_q     <= hold_d;
      pc_clear_q <= pc_clear_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign imem_wr_en   = wr_en_q;
  assign imem_wr_addr = idx_q;
  assign imem_wr_data = bios_word[idx_q];
  assign cpu_hold     = hold_q;
  assign cpu_pc_clear = pc_clear_q;
  assign boot_done    = done_q;
  assign boot_error   = error_q;
  assign words_loaded = loaded_q;

endmodule

// File: tb/tb_bios_boot_loader.sv
// Bench for bios_boot_loader: scoreboard of expected (addr,data) writes, popped on each acked write.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_bios_boot_loader;
  localparam int WORD_W  = 16;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 15;

  logic                    clock = 1'b0;
  logic                    reset_n;
  logic [DEPTH*WORD_W-1:0] bios_flat;
  logic                    reload;
  logic                    imem_wr_ack;
  logic                    imem_wr_en;
  logic [ADDR_W-1:0]       imem_wr_addr;
  logic [WORD_W-1:0]       imem_wr_data;
  logic                    cpu_hold;
  logic                    cpu_pc_clear;
  logic                    boot_done;
  logic                    boot_error;
  logic [ADDR_W:0]         words_loaded;

  always #5 clock = ~clock;

  bios_boot_loader #(
    .WORD_W(WORD_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset_n(reset_n), .bios_flat(bios_flat), .reload(reload),
    .imem_wr_ack(imem_wr_ack), .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr),
    .imem_wr_data(imem_wr_data), .cpu_hold(cpu_hold), .cpu_pc_clear(cpu_pc_clear),
    .boot_done(boot_done), .boot_error(boot_error), .words_loaded(words_loaded)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   stall_plan[DEPTH];
  int   reload_word = -1;
  int   abort_word  = -1;
  int   res_end, res_edges, res_pc, res_waited;

  task automatic push_pass();
    exp_t e;
    for (int k = 0; k < DEPTH; k++) begin
      e.addr = ADDR_W'(k);
      e.data = bios_flat[WORD_W*k +: WORD_W];
      sb_q.push_back(e);
    end
  endtask

  task automatic clear_stalls();
    for (int k = 0; k < DEPTH; k++) stall_plan[k] = 0;
  endtask

  // Runs one pass from START. res_end: 1 done, 2 fault, 3 aborted at abort_word, 0 ran out of cycles.
  task automatic drive_copy();
    int cur = 0;
    int waited = 0;
    int stall_len;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [WORD_W-1:0] prev_data = '0;
    exp_t e;
    res_end = 0; res_edges = -1; res_pc = 0; res_waited = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (boot_done) begin res_end = 1; res_edges = cyc; break; end
      if (boot_error) begin res_end = 2; res_edges = cyc; res_waited = waited; break; end
      if (imem_wr_en && cur == abort_word) begin res_end = 3; break; end
      total++;
      if (cpu_hold !== 1'b1) begin
        bad++; $display("FAIL hold_during_copy cyc=%0d got=%b want=1", cyc, cpu_hold);
      end
      if (cpu_pc_clear === 1'b1) res_pc++;
      reload = imem_wr_en && (cur == reload_word);
      if (imem_wr_en) begin
        if (waited > 0) begin
          total++;
          if (imem_wr_addr !== prev_addr || imem_wr_data !== prev_data) begin
            bad++;
            $display("FAIL stable_while_wait got=%h/%h want=%h/%h",
                     imem_wr_addr, imem_wr_data, prev_addr, prev_data);
          end
        end
        prev_addr = imem_wr_addr;
        prev_data = imem_wr_data;
        stall_len = (cur < DEPTH) ? stall_plan[cur] : 0;
        if (waited >= stall_len) begin
          imem_wr_ack = 1'b1;
          total++;
          if (sb_q.size() == 0) begin
            bad++; $display("FAIL extra_write got=%h/%h want=none", imem_wr_addr, imem_wr_data);
          end else begin
            e = sb_q.pop_front();
            if (imem_wr_addr !== e.addr || imem_wr_data !== e.data) begin
              bad++;
              $display("FAIL write_order got=%h/%h want=%h/%h",
                       imem_wr_addr, imem_wr_data, e.addr, e.data);
            end
          end
          cur++;
          waited = 0;
        end else begin
          imem_wr_ack = 1'b0;
          waited++;
        end
      end else begin
        imem_wr_ack = 1'b0;
      end
      @(negedge clock);
    end
    imem_wr_ack = 1'b0;
    reload = 1'b0;
    if (res_end == 0) begin
      total++; bad++; $display("FAIL copy_budget got=no_end want=done_or_fault");
    end
  endtask

  // From DONE or FAULT: pulse reload, check the START cycle.
  task automatic restart_pass();
    reload = 1'b1;
    @(negedge clock);
    reload = 1'b0;
    total++;
    if (boot_done !== 1'b0 || cpu_hold !== 1'b1 || boot_error !== 1'b0 || imem_wr_en !== 1'b0) begin
      bad++;
      $display("FAIL start_after_reload got=done%b hold%b err%b en%b want=done0 hold1 err0 en0",
               boot_done, cpu_hold, boot_error, imem_wr_en);
    end
    push_pass();
  endtask

  task automatic check_done(input int want_edges);
    total++;
    if (res_end !== 1) begin bad++; $display("FAIL pass_end got=%0d want=1", res_end); end
    total++;
    if (res_edges !== want_edges) begin
      bad++; $display("FAIL edges_to_done got=%0d want=%0d", res_edges, want_edges);
    end
    total++;
    if (res_pc !== 1) begin bad++; $display("FAIL pc_clear_pulses got=%0d want=1", res_pc); end
    total++;
    if (words_loaded !== 5'd16 || cpu_hold !== 1'b0 || imem_wr_en !== 1'b0 || boot_error !== 1'b0) begin
      bad++;
      $display("FAIL done_outputs got=wl%0d hold%b en%b err%b want=wl16 hold0 en0 err0",
               words_loaded, cpu_hold, imem_wr_en, boot_error);
    end
    total++;
    if (sb_q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d want=0", sb_q.size()); end
  endtask

  task automatic check_reset_vals(input string tag);
    total++;
    if (imem_wr_en !== 1'b0 || imem_wr_addr !== '0 || cpu_hold !== 1'b1 || cpu_pc_clear !== 1'b0 ||
        boot_done !== 1'b0 || boot_error !== 1'b0 || words_loaded !== '0) begin
      bad++;
      $display("FAIL %s got=en%b a%h hold%b pc%b done%b err%b wl%0d want=en0 a0 hold1 pc0 done0 err0 wl0",
               tag, imem_wr_en, imem_wr_addr, cpu_hold, cpu_pc_clear, boot_done, boot_error, words_loaded);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; reload = 1'b0; imem_wr_ack = 1'b0;
    for (int k = 0; k < DEPTH; k++) bios_flat[WORD_W*k +: WORD_W] = WORD_W'($urandom);
    @(negedge clock);
    @(negedge clock);
    check_reset_vals("reset_state");
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    clear_stalls();
    push_pass();
    drive_copy();
    check_done(18);
  endtask

  task automatic test_fault();
    clear_stalls();
    stall_plan[5] = 100;
    restart_pass();
    drive_copy();
    total++;
    if (res_end !== 2 || res_waited !== TIMEOUT) begin
      bad++; $display("FAIL fault_timing got=end%0d wait%0d want=end2 wait%0d", res_end, res_waited, TIMEOUT);
    end
    repeat (3) @(negedge clock);
    total++;
    if (boot_error !== 1'b1 || words_loaded !== 5'd5 || imem_wr_en !== 1'b0 || cpu_hold !== 1'b1 ||
        boot_done !== 1'b0) begin
      bad++;
      $display("FAIL fault_outputs got=err%b wl%0d en%b hold%b done%b want=err1 wl5 en0 hold1 done0",
               boot_error, words_loaded, imem_wr_en, cpu_hold, boot_done);
    end
    sb_q.delete();
    clear_stalls();
    restart_pass();
    drive_copy();
    check_done(18);
  endtask

  task automatic test_ack_late();
    clear_stalls();
    stall_plan[3] = TIMEOUT - 1;
    restart_pass();
    drive_copy();
    check_done(18 + TIMEOUT - 1);
  endtask

  task automatic test_reset_mid();
    clear_stalls();
    abort_word = 9;
    restart_pass();
    drive_copy();
    abort_word = -1;
    total++;
    if (res_end !== 3) begin bad++; $display("FAIL reach_word9 got=%0d want=3", res_end); end
    #2 reset_n = 1'b0;
    #1 check_reset_vals("async_reset");
    @(negedge clock);
    reset_n = 1'b1;
    sb_q.delete();
    push_pass();
    drive_copy();
    check_done(18);
  endtask

  task automatic test_reload();
    clear_stalls();
    stall_plan[6] = 3;
    reload_word = 6;
    restart_pass();
    drive_copy();
    reload_word = -1;
    check_done(21);
  endtask

  task automatic test_random();
    int sum;
    for (int p = 0; p < 3; p++) begin
      sum = 0;
      for (int k = 0; k < DEPTH; k++) begin
        stall_plan[k] = $urandom_range(0, TIMEOUT - 1);
        sum += stall_plan[k];
      end
      for (int k = 0; k < DEPTH; k++) bios_flat[WORD_W*k +: WORD_W] = WORD_W'($urandom);
      restart_pass();
      drive_copy();
      check_done(18 + sum);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fault();
    test_ack_late();
    test_reset_mid();
    test_reload();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=stuck want=finish");
    $fatal(1, "watchdog");
  end

endmodule
